id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 66 ++++++
 rtl/id_ex_stage_if.sv | 61 ++++++
 rtl/id_ex_stage_hazard_detect.sv | 32 +++
 rtl/id_ex_stage.sv | 161 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pkg -- shared pipeline definitions for the ID/EX boundary.
//
// Contents:
//   * width localparams for data and register indices
//   * alu_op_e  : 3-bit ALU operation encoding carried in the control bundle
//   * ctrl_t    : 10-bit control bundle
//                 {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, Jump,
//                  ALUOp[2:0]}, RegWrite being bit 9
//   * ex_regs_t : the complete set of ID/EX pipeline registers
//   * stall_state_e : load-use stall FSM encoding
//   * sat_inc() : saturating 32-bit increment
// -----------------------------------------------------------------------------
package id_ex_stage_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 10;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'b000,
        ALU_SUB    = 3'b001,
        ALU_RTYPE  = 3'b010,
        ALU_ITYPE  = 3'b011,
        ALU_BRANCH = 3'b100,
        ALU_LUI    = 3'b101,
        ALU_AUIPC  = 3'b110,
        ALU_PASS   = 3'b111
    } alu_op_e;

    // Field order defines bit positions: reg_write is bit 9, alu_op is [2:0].
    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        logic    branch;
        logic    jump;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_v;
        logic [XLEN-1:0]   rs2_v;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [REG_AW-1:0] rd_addr;
        ctrl_t             ctrl;
    } ex_regs_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } stall_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if -- bundle of all non-clock signals of the ID/EX stage.
//
// Signals:
//   ID_valid, ID_pc, ID_rs1_v, ID_rs2_v, ID_imm,
//   ID_rs1_addr, ID_rs2_addr, ID_rd_addr, ID_ctrl   decode-side instruction
//   flush   branch/jump taken in EX, squash decode
//   hold    global freeze from the memory side
//   EX_*    registered copies feeding EX forwarding
//   pc_write, if_id_write   enables for PC and IF/ID registers
//   stall_cnt               load-use stall cycle counter
//
// Modports:
//   master : decode/control side (drives ID_*, flush, hold)
//   slave  : the id_ex_stage itself
// -----------------------------------------------------------------------------
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic              ID_valid;
    logic [XLEN-1:0]   ID_pc;
    logic [XLEN-1:0]   ID_rs1_v;
    logic [XLEN-1:0]   ID_rs2_v;
    logic [XLEN-1:0]   ID_imm;
    logic [REG_AW-1:0] ID_rs1_addr;
    logic [REG_AW-1:0] ID_rs2_addr;
    logic [REG_AW-1:0] ID_rd_addr;
    ctrl_t             ID_ctrl;
    logic              flush;
    logic              hold;

    logic              EX_valid;
    logic [XLEN-1:0]   EX_pc;
    logic [XLEN-1:0]   EX_rs1_v;
    logic [XLEN-1:0]   EX_rs2_v;
    logic [XLEN-1:0]   EX_imm;
    logic [REG_AW-1:0] EX_rs1_addr;
    logic [REG_AW-1:0] EX_rs2_addr;
    logic [REG_AW-1:0] EX_rd_addr;
    ctrl_t             EX_ctrl;
    logic              pc_write;
    logic              if_id_write;
    logic [31:0]       stall_cnt;

    modport master (
        output ID_valid, ID_pc, ID_rs1_v, ID_rs2_v, ID_imm,
               ID_rs1_addr, ID_rs2_addr, ID_rd_addr, ID_ctrl, flush, hold,
        input  EX_valid, EX_pc, EX_rs1_v, EX_rs2_v, EX_imm,
               EX_rs1_addr, EX_rs2_addr, EX_rd_addr, EX_ctrl,
               pc_write, if_id_write, stall_cnt
    );

    modport slave (
        input  ID_valid, ID_pc, ID_rs1_v, ID_rs2_v, ID_imm,
               ID_rs1_addr, ID_rs2_addr, ID_rd_addr, ID_ctrl, flush, hold,
        output EX_valid, EX_pc, EX_rs1_v, EX_rs2_v, EX_imm,
               EX_rs1_addr, EX_rs2_addr, EX_rd_addr, EX_ctrl,
               pc_write, if_id_write, stall_cnt
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect -- purely combinational load-use comparator.
//
// Ports:
//   ex_valid, ex_mem_read, ex_rd_addr   instruction currently in EX
//   id_valid, id_rs1_addr, id_rs2_addr  instruction currently in ID
//   load_use                            ID needs a value EX is still loading
//
// Both source indices are compared even if the consumer ignores rs2; the
// occasional unnecessary stall is cheaper than decoding operand usage here.
// x0 is never a real destination, so a load to x0 never stalls.
// -----------------------------------------------------------------------------
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd_addr,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    output logic              load_use
);

    logic rd_nonzero;
    logic src_match;

    assign rd_nonzero = (ex_rd_addr != '0);
    assign src_match  = (ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr);
    assign load_use   = ex_valid && ex_mem_read && rd_nonzero && id_valid && src_match;

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage -- ID/EX pipeline register with load-use stall insertion.
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    id_ex_stage_if.slave (ID_* in, flush, hold, EX_* out,
//          pc_write, if_id_write, stall_cnt)
//
// Priority of per-cycle actions: hold > flush > load-use > normal load.
//   hold     : every EX_* register and the stall FSM keep their value,
//              PC and IF/ID are frozen.
//   flush    : a bubble (valid=0, ctrl=0) enters EX, front end keeps running.
//   load-use : a bubble enters EX, PC and IF/ID are frozen for that cycle so
//              the consumer re-presents itself and enters EX on the next edge.
// A bubble still copies the ID data fields; only valid and ctrl are cleared.
//
// Configuration:
//   ID_EX_STALL_CNT_EN  defined   -> saturating 32-bit stall_cnt counter
//                       undefined -> stall_cnt tied to 0, no counter flops
// -----------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);

    ex_regs_t     ex_q;
    ex_regs_t     ex_d;
    stall_state_e state_q;
    stall_state_e state_d;
    logic         load_use;
    logic         bubble;
    logic         accept_stall;
    logic         front_en;

    // ------------------------------------------------------------------
    // Hazard comparator looks at the registered EX state and live ID.
    // ------------------------------------------------------------------
    hazard_detect u_hazard_detect (
        .ex_valid    (ex_q.valid),
        .ex_mem_read (ex_q.ctrl.mem_read),
        .ex_rd_addr  (ex_q.rd_addr),
        .id_valid    (bus.ID_valid),
        .id_rs1_addr (bus.ID_rs1_addr),
        .id_rs2_addr (bus.ID_rs2_addr),
        .load_use    (load_use)
    );

    assign bubble       = bus.flush || load_use;
    assign accept_stall = load_use && !bus.flush && !bus.hold;

    // ------------------------------------------------------------------
    // Next value of the ID/EX registers.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: start from the held value so every path assigns ex_d; a
        // missing branch would otherwise infer a latch.
        ex_d = ex_q;
        if (!bus.hold) begin
            ex_d.pc       = bus.ID_pc;
            ex_d.rs1_v    = bus.ID_rs1_v;
            ex_d.rs2_v    = bus.ID_rs2_v;
            ex_d.imm      = bus.ID_imm;
            ex_d.rs1_addr = bus.ID_rs1_addr;
            ex_d.rs2_addr = bus.ID_rs2_addr;
            ex_d.rd_addr  = bus.ID_rd_addr;
            ex_d.valid    = bus.ID_valid && !bubble;
            // An empty slot must never carry live control into EX.
            ex_d.ctrl     = ex_d.valid ? bus.ID_ctrl : CTRL_NOP;
        end
    end

    // NOTE: the data fields are reset along with valid/ctrl because
    // downstream forwarding compares EX_rd_addr directly and reset must
    // present all-zero EX outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values
            // regardless of statement order across always_ff blocks.
            ex_q <= ex_d;
        end
    end

    // ------------------------------------------------------------------
    // Stall FSM: RUN -> STALL on an accepted load-use, STALL -> RUN on
    // the next cycle unless another load-use is accepted; hold freezes it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        front_en = 1'b1;
        unique case (state_q)
            ST_RUN: begin
                if (bus.hold) begin
                    front_en = 1'b0;
                end else if (accept_stall) begin
                    state_d  = ST_STALL;
                    front_en = 1'b0;
                end
            end
            ST_STALL: begin
                if (bus.hold) begin
                    front_en = 1'b0;
                end else if (accept_stall) begin
                    front_en = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // While in reset the front end must be free to refetch from the reset PC.
    assign bus.pc_write    = !rst_n || front_en;
    assign bus.if_id_write = !rst_n || front_en;

    // ------------------------------------------------------------------
    // Optional stall counter.
    // ------------------------------------------------------------------
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (accept_stall) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = '0;
`endif

    // ------------------------------------------------------------------
    // Output mapping.
    // ------------------------------------------------------------------
    assign bus.EX_valid    = ex_q.valid;
    assign bus.EX_pc       = ex_q.pc;
    assign bus.EX_rs1_v    = ex_q.rs1_v;
    assign bus.EX_rs2_v    = ex_q.rs2_v;
    assign bus.EX_imm      = ex_q.imm;
    assign bus.EX_rs1_addr = ex_q.rs1_addr;
    assign bus.EX_rs2_addr = ex_q.rs2_addr;
    assign bus.EX_rd_addr  = ex_q.rd_addr;
    assign bus.EX_ctrl     = ex_q.ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage -- self-checking bench for id_ex_stage.
//
// A behavioural model of the ID/EX boundary is advanced on every rising edge
// and compared against the DUT after inputs settle each cycle. Directed
// scenarios add literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

`ifdef ID_EX_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // Control bundle values, bit 9 = RegWrite, bit 8 = MemRead.
    localparam logic [9:0] C_LW  = 10'h360; // RegWrite|MemRead|MemtoReg|ALUSrc
    localparam logic [9:0] C_ADD = 10'h202; // RegWrite, R-type ALUOp

    logic clk;
    logic rst_n;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total;
    int n_pass;

    // Model state: what EX must hold.
    logic        m_valid;
    logic [31:0] m_pc, m_rs1_v, m_rs2_v, m_imm;
    logic [4:0]  m_rs1a, m_rs2a, m_rda;
    logic [9:0]  m_ctrl;
    logic [31:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_pc = '0; m_rs1_v = '0; m_rs2_v = '0; m_imm = '0;
        m_rs1a = '0; m_rs2a = '0; m_rda = '0; m_ctrl = '0; m_cnt = '0;
    endtask

    // EX holds a valid load whose destination ID is about to read.
    function automatic bit model_load_use();
        return m_valid && m_ctrl[8] && (m_rda != 5'd0) && bus.ID_valid &&
               ((m_rda == bus.ID_rs1_addr) || (m_rda == bus.ID_rs2_addr));
    endfunction

    function automatic bit model_front_en();
        if (!rst_n)         return 1'b1;
        if (bus.hold)       return 1'b0;
        if (bus.flush)      return 1'b1;
        if (model_load_use()) return 1'b0;
        return 1'b1;
    endfunction

    // Called at the rising edge with the pre-edge inputs and model state.
    task automatic model_edge();
        bit lu;
        bit squash;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (bus.hold) return;
        lu     = model_load_use();
        squash = bus.flush || lu;
        if (lu && !bus.flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        m_pc   = bus.ID_pc;   m_rs1_v = bus.ID_rs1_v; m_rs2_v = bus.ID_rs2_v;
        m_imm  = bus.ID_imm;  m_rs1a  = bus.ID_rs1_addr;
        m_rs2a = bus.ID_rs2_addr; m_rda = bus.ID_rd_addr;
        m_valid = bus.ID_valid && !squash;
        m_ctrl  = m_valid ? bus.ID_ctrl : 10'h000;
    endtask

    task automatic compare_all();
        check("EX_valid",    {31'd0, bus.EX_valid},    {31'd0, m_valid});
        check("EX_pc",       bus.EX_pc,                m_pc);
        check("EX_rs1_v",    bus.EX_rs1_v,             m_rs1_v);
        check("EX_rs2_v",    bus.EX_rs2_v,             m_rs2_v);
        check("EX_imm",      bus.EX_imm,               m_imm);
        check("EX_rs1_addr", {27'd0, bus.EX_rs1_addr}, {27'd0, m_rs1a});
        check("EX_rs2_addr", {27'd0, bus.EX_rs2_addr}, {27'd0, m_rs2a});
        check("EX_rd_addr",  {27'd0, bus.EX_rd_addr},  {27'd0, m_rda});
        check("EX_ctrl",     {22'd0, bus.EX_ctrl},     {22'd0, m_ctrl});
        check("pc_write",    {31'd0, bus.pc_write},    {31'd0, model_front_en()});
        check("if_id_write", {31'd0, bus.if_id_write}, {31'd0, model_front_en()});
        check("stall_cnt",   bus.stall_cnt,            CNT_EN ? m_cnt : 32'd0);
    endtask

    // Let combinational outputs settle after new inputs, then compare.
    task automatic settle();
        #1;
        if (!rst_n) model_reset();
        compare_all();
    endtask

    // Cross the rising edge (model follows) and return at the falling edge.
    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [9:0] ctrl);
        bus.ID_valid    = v;
        bus.ID_pc       = pc;
        bus.ID_rs1_v    = $urandom;
        bus.ID_rs2_v    = $urandom;
        bus.ID_imm      = $urandom;
        bus.ID_rs1_addr = rs1;
        bus.ID_rs2_addr = rs2;
        bus.ID_rd_addr  = rd;
        bus.ID_ctrl     = ctrl;
    endtask

    logic [31:0] exp_cnt1;

    initial begin
        n_total = 0;
        n_pass  = 0;
        exp_cnt1 = CNT_EN ? 32'd1 : 32'd0;
        model_reset();

        // Reset state, with hold asserted to show reset still frees the front end.
        rst_n     = 1'b0;
        bus.flush = 1'b0;
        bus.hold  = 1'b1;
        set_id(1'b1, 32'h1234, 5'd1, 5'd2, 5'd3, C_ADD);
        @(negedge clk);
        settle();
        check("rst EX_valid", {31'd0, bus.EX_valid}, 32'd0);
        check("rst EX_pc", bus.EX_pc, 32'd0);
        check("rst pc_write", {31'd0, bus.pc_write}, 32'd1);
        check("rst stall_cnt", bus.stall_cnt, 32'd0);
        advance();
        bus.hold = 1'b0;
        rst_n    = 1'b1;

        // lw x5 ; add x6,x5,x7 -> one stall cycle, bubble, then add enters EX.
        set_id(1'b1, 32'h40, 5'd1, 5'd2, 5'd5, C_LW);
        settle(); advance();
        set_id(1'b1, 32'h44, 5'd5, 5'd7, 5'd6, C_ADD);
        settle();
        check("lu pc_write", {31'd0, bus.pc_write}, 32'd0);
        check("lu if_id_write", {31'd0, bus.if_id_write}, 32'd0);
        advance();
        settle();
        check("lu bubble valid", {31'd0, bus.EX_valid}, 32'd0);
        check("lu bubble ctrl", {22'd0, bus.EX_ctrl}, 32'd0);
        check("lu resume pc_write", {31'd0, bus.pc_write}, 32'd1);
        advance();
        settle();
        check("lu add valid", {31'd0, bus.EX_valid}, 32'd1);
        check("lu add rs1", {27'd0, bus.EX_rs1_addr}, 32'd5);
        check("lu add pc", bus.EX_pc, 32'h44);
        check("lu stall_cnt", bus.stall_cnt, exp_cnt1);
        advance();

        // lw x0 followed by a reader of x0 -> no stall.
        set_id(1'b1, 32'h48, 5'd3, 5'd4, 5'd0, C_LW);
        settle(); advance();
        set_id(1'b1, 32'h4C, 5'd0, 5'd0, 5'd1, C_ADD);
        settle();
        check("x0 pc_write", {31'd0, bus.pc_write}, 32'd1);
        advance();
        settle();
        check("x0 EX_pc", bus.EX_pc, 32'h4C);
        check("x0 EX_valid", {31'd0, bus.EX_valid}, 32'd1);
        advance();

        // Load-use together with flush -> bubble, front end runs, no count.
        set_id(1'b1, 32'h50, 5'd1, 5'd2, 5'd5, C_LW);
        settle(); advance();
        set_id(1'b1, 32'h54, 5'd5, 5'd9, 5'd6, C_ADD);
        bus.flush = 1'b1;
        settle();
        check("flush pc_write", {31'd0, bus.pc_write}, 32'd1);
        check("flush if_id_write", {31'd0, bus.if_id_write}, 32'd1);
        advance();
        bus.flush = 1'b0;
        set_id(1'b1, 32'h58, 5'd1, 5'd2, 5'd3, C_ADD);
        settle();
        check("flush bubble valid", {31'd0, bus.EX_valid}, 32'd0);
        check("flush bubble ctrl", {22'd0, bus.EX_ctrl}, 32'd0);
        check("flush bubble pc", bus.EX_pc, 32'h54);
        check("flush stall_cnt", bus.stall_cnt, exp_cnt1);
        advance();

        // Hold for 3 cycles over a pending load-use: everything frozen.
        set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd5, C_LW);
        settle(); advance();
        bus.hold = 1'b1;
        set_id(1'b1, 32'h200, 5'd5, 5'd5, 5'd9, C_ADD);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("hold EX_pc", bus.EX_pc, 32'h100);
            check("hold pc_write", {31'd0, bus.pc_write}, 32'd0);
            advance();
        end
        bus.hold = 1'b0;
        set_id(1'b1, 32'h204, 5'd1, 5'd2, 5'd3, C_ADD);
        settle();
        check("hold stall_cnt", bus.stall_cnt, exp_cnt1);
        check("hold EX_ctrl", {22'd0, bus.EX_ctrl}, {22'd0, C_LW});
        advance();

        // Empty decode slot with all control bits set.
        set_id(1'b0, 32'h300, 5'd1, 5'd2, 5'd3, 10'h3FF);
        settle(); advance();
        settle();
        check("novalid EX_ctrl", {22'd0, bus.EX_ctrl}, 32'd0);
        check("novalid EX_valid", {31'd0, bus.EX_valid}, 32'd0);
        advance();

        // Reset pulsed mid-stall.
        set_id(1'b1, 32'h400, 5'd1, 5'd2, 5'd5, C_LW);
        settle(); advance();
        set_id(1'b1, 32'h404, 5'd5, 5'd0, 5'd6, C_ADD);
        settle(); advance();
        rst_n = 1'b0;
        settle();
        check("midrst EX_pc", bus.EX_pc, 32'd0);
        check("midrst EX_valid", {31'd0, bus.EX_valid}, 32'd0);
        check("midrst EX_rs1_addr", {27'd0, bus.EX_rs1_addr}, 32'd0);
        check("midrst EX_imm", bus.EX_imm, 32'd0);
        check("midrst pc_write", {31'd0, bus.pc_write}, 32'd1);
        check("midrst stall_cnt", bus.stall_cnt, 32'd0);
        advance();
        rst_n = 1'b1;
        set_id(1'b1, 32'h0, 5'd5, 5'd0, 5'd6, C_ADD);
        settle();
        check("postrst pc_write", {31'd0, bus.pc_write}, 32'd1);
        advance();
        settle();
        check("postrst EX_pc", bus.EX_pc, 32'h0);
        check("postrst EX_valid", {31'd0, bus.EX_valid}, 32'd1);
        check("postrst EX_ctrl", {22'd0, bus.EX_ctrl}, {22'd0, C_ADD});
        advance();

        // Randomized phase: small register range to provoke hazards often.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [9:0] c;
            rst_n     = ($urandom_range(0, 199) != 0);
            bus.hold  = ($urandom_range(0, 7) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            c = 10'($urandom);
            c[8] = ($urandom_range(0, 1) == 1);
            set_id($urandom_range(0, 4) != 0, $urandom,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), c);
            settle();
            advance();
        end

        rst_n = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
